// File: rtl/sram_ext_pkg.sv
// Shared constants for the SRAM external-port initiator.
package sram_ext_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DUMP = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   localparam int WORD_BYTES  = 4;
   localparam int MACRO_DEPTH = 128;

   localparam logic MODE_LOAD = 1'b0;
   localparam logic MODE_DUMP = 1'b1;
endpackage

// File: rtl/sram_rd_skid_fifo.sv
// Two-entry skid FIFO that catches SRAM read data for the DUMP stream.
// The head word stays put until it is popped, so the output is stable under backpressure.
module sram_rd_skid_fifo #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        count
);
   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sram_ext_port_ctrl.sv
// External-port initiator: LOAD streams words into consecutive SRAM addresses,
// DUMP reads consecutive words out through a 2-entry skid FIFO with backpressure.
module sram_ext_port_ctrl
   import sram_ext_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [63:0]       base_addr,
   input  logic [ADDR_W:0]   num_words,
   output logic              busy,
   output logic              done,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [63:0]       addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [DATA_W-1:0] wdata_ext,
   input  logic [DATA_W-1:0] rdata_ext
);
   localparam logic [ADDR_W:0] CNT_ZERO = '0;
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state, state_nxt;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W:0]   issue_left;   // accesses still to issue (writes or reads)
   logic [ADDR_W:0]   out_left;     // DUMP words still to hand out on m_*
   logic              in_flight;    // read issued last cycle, data on rdata_ext now
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        fifo_count;
   logic [2:0]        credit_used;
   logic              accept, w_fire, m_fire;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{base_addr[63:ADDR_W+2], base_addr[1:0]};

   assign accept    = (state == ST_IDLE) && start;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FIN);
   assign s_ready   = (state == ST_LOAD);
   assign w_fire    = s_ready && s_valid;
   assign wen_ext   = w_fire;
   assign wdata_ext = w_fire ? s_data : wdata_q;
   assign addr_ext  = {{(64-ADDR_W-2){1'b0}}, word_idx, 2'b00};
   assign m_valid   = (fifo_count != 2'd0);
   assign m_fire    = m_valid && m_ready;

   // A word leaving the FIFO this cycle frees its slot, which keeps DUMP at one word per cycle.
   assign credit_used = {2'b00, in_flight} + {1'b0, fifo_count} - {2'b00, m_fire};
   assign ren_ext     = (state == ST_DUMP) && (issue_left != CNT_ZERO) && (credit_used < 3'd2);

   sram_rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_flight),
      .pop   (m_fire),
      .wdata (rdata_ext),
      .rdata (m_data),
      .count (fifo_count)
   );

   // Next-state: a zero-length command goes straight to FIN so it still reports done.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) begin
            if (num_words == CNT_ZERO)   state_nxt = ST_FIN;
            else if (mode == MODE_DUMP)  state_nxt = ST_DUMP;
            else                         state_nxt = ST_LOAD;
         end
         ST_LOAD: if (w_fire && (issue_left == CNT_ONE)) state_nxt = ST_FIN;
         ST_DUMP: if (m_fire && (out_left == CNT_ONE))   state_nxt = ST_FIN;
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, address/length counters, read-in-flight flag and held write data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         word_idx   <= '0;
         issue_left <= '0;
         out_left   <= '0;
         in_flight  <= 1'b0;
         wdata_q    <= '0;
      end else begin
         state     <= state_nxt;
         in_flight <= ren_ext;
         if (accept) begin
            word_idx   <= base_addr[ADDR_W+1:2];
            issue_left <= num_words;
            out_left   <= num_words;
         end else begin
            if (w_fire || ren_ext) begin
               word_idx   <= word_idx + 1'b1;
               issue_left <= issue_left - CNT_ONE;
            end
            if (m_fire) out_left <= out_left - CNT_ONE;
         end
         if (w_fire) wdata_q <= s_data;
      end
   end
endmodule
